// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Wide adder built from one external 4-bit ripple stage, used one nibble
//   per clock. Operands are latched on an accepted start. Each RUN cycle
//   drives the adder with one nibble pair plus the carry register, then
//   stores the adder's sum nibble and carry-out.
//
//   Parameter: NIBBLES (1..16), operand width W = 4*NIBBLES.
//   Optional:  NIBSER_SUB_EN adds port 'sub'. When sub=1, B is inverted and
//              the first carry is forced to 1, giving A-B (cout=1: no borrow).
//
//   Ports:
//     clk, rst            clock, async active-high reset
//     start               request, accepted only in IDLE
//     op_a, op_b, cin     operands, sampled on accepted start
//     sub                 (NIBSER_SUB_EN only) subtract select, sampled with start
//     busy, done          busy during RUN, done is a one-cycle result pulse
//     sum, cout           result registers, held until the next accepted start
//     add_a/add_b/add_cin drive to the external 4-bit adder (0 outside RUN)
//     add_s/add_cout      combinational result from the external adder

// One result nibble. It is cleared on an accepted start and loaded during
// its own RUN cycle.
module nibser_lane (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       we,
   input  logic [3:0] d,
   output logic [3:0] q
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      q <= 4'h0;
      else if (clr) q <= 4'h0;
      else if (we)  q <= d;
   end
endmodule

module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
`ifdef NIBSER_SUB_EN
   input  logic                 sub,
`endif
   input  logic [4*NIBBLES-1:0] op_a,
   input  logic [4*NIBBLES-1:0] op_b,
   input  logic                 cin,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout,
   output logic [3:0]           add_a,
   output logic [3:0]           add_b,
   output logic                 add_cin,
   input  logic [3:0]           add_s,
   input  logic                 add_cout
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                    state;
   logic [NIBBLES-1:0][3:0]   a_reg, b_reg;
   logic                      carry;
   logic [IW-1:0]             idx;
   logic [W-1:0]              b_in;
   logic                      c_in;
   logic                      accept, last;
   logic [3:0]                a_sel, b_sel;
   logic [NIBBLES-1:0]        lane_we;
   logic [NIBBLES-1:0][3:0]   sum_lanes;

   // Subtract is A + ~B + 1. The forced carry overrides cin.
`ifdef NIBSER_SUB_EN
   assign b_in = sub ? ~op_b : op_b;
   assign c_in = sub | cin;
`else
   assign b_in = op_b;
   assign c_in = cin;
`endif

   assign accept = (state == S_IDLE) && start;
   assign last   = (idx == IW'(NIBBLES - 1));

   // Nibble select by compare rather than a variable index, so that
   // NIBBLES values that are not a power of two (and NIBBLES=1) stay clean.
   always_comb begin
      a_sel = 4'h0;
      b_sel = 4'h0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx == IW'(i)) begin
            a_sel = a_reg[i];
            b_sel = b_reg[i];
         end
      end
   end

   assign add_a   = (state == S_RUN) ? a_sel : 4'h0;
   assign add_b   = (state == S_RUN) ? b_sel : 4'h0;
   assign add_cin = (state == S_RUN) ? carry : 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         cout  <= 1'b0;
         a_reg <= '0;
         b_reg <= '0;
         carry <= 1'b0;
         idx   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_reg <= op_a;
                  b_reg <= b_in;
                  carry <= c_in;
                  idx   <= '0;
                  cout  <= 1'b0;
                  busy  <= 1'b1;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               carry <= add_cout;
               if (last) begin
                  // idx stays on the last nibble. It is reset on the next accept.
                  cout  <= add_cout;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   for (genvar g = 0; g < NIBBLES; g++) begin : g_lane
      assign lane_we[g] = (state == S_RUN) && (idx == IW'(g));
      nibser_lane u_lane (
         .clk (clk),
         .rst (rst),
         .clr (accept),
         .we  (lane_we[g]),
         .d   (add_s),
         .q   (sum_lanes[g])
      );
   end

   assign sum = sum_lanes;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;
   localparam int N = 4;
   localparam int W = 4 * N;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         start = 1'b0, cin = 1'b0, sub = 1'b0;
   logic [W-1:0] op_a = '0, op_b = '0;
   logic         busy, done, cout, add_cin, add_cout;
   logic [W-1:0] sum;
   logic [3:0]   add_a, add_b, add_s;

   // External 4-bit ripple adder.
   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};

   nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
      .clk(clk), .rst(rst), .start(start),
`ifdef NIBSER_SUB_EN
      .sub(sub),
`endif
      .op_a(op_a), .op_b(op_b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_s(add_s), .add_cout(add_cout));

   // Single-nibble instance
   logic       start1 = 1'b0, cin1 = 1'b0;
   logic [3:0] a1 = '0, b1 = '0, sum1, add_a1, add_b1, add_s1;
   logic       busy1, done1, cout1, add_cin1, add_cout1;
   assign {add_cout1, add_s1} = {1'b0, add_a1} + {1'b0, add_b1} + {4'h0, add_cin1};

   nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1),
`ifdef NIBSER_SUB_EN
      .sub(1'b0),
`endif
      .op_a(a1), .op_b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
      .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
      .add_s(add_s1), .add_cout(add_cout1));

   int errors = 0, checks = 0;

   task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model. phase 0 = idle, 1..N = busy cycle (phase-1),
   // N+1 = done cycle. res is the full W+1 bit arithmetic result.
   int           phase = 0;
   logic [W-1:0] ma = '0, mb = '0, hsum = '0;
   logic         mc = 1'b0, hcout = 1'b0;
   logic [W:0]   res = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         phase = 0; hsum = '0; hcout = 1'b0;
      end else if (phase == 0) begin
         if (start) begin
            logic s_eff;
`ifdef NIBSER_SUB_EN
            s_eff = sub;
`else
            s_eff = 1'b0;
`endif
            ma  = op_a;
            mb  = s_eff ? ~op_b : op_b;
            mc  = s_eff ? 1'b1 : cin;
            res = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
            hsum = '0; hcout = 1'b0;
            phase = 1;
         end
      end else if (phase <= N) begin
         phase++;
         if (phase == N + 1) begin
            hsum = res[W-1:0]; hcout = res[W];
         end
      end else begin
         phase = 0;
      end
   end

   bit cmp_en = 0;
   always @(negedge clk) begin
      if (cmp_en && !rst) begin
         int ci;
         logic [W:0] mask, cexp;
         chk("busy", busy, (phase >= 1 && phase <= N));
         chk("done", done, (phase == N + 1));
         if (phase >= 1 && phase <= N) begin
            ci   = phase - 1;
            mask = ({{W{1'b0}}, 1'b1} << (4 * ci)) - 1'b1;
            cexp = (({1'b0, ma} & mask) + ({1'b0, mb} & mask) + {{W{1'b0}}, mc}) >> (4 * ci);
            chk("add_a", add_a, ma[4*ci +: 4]);
            chk("add_b", add_b, mb[4*ci +: 4]);
            chk("add_cin", add_cin, cexp[0]);
            chk("sum_partial", sum, res[W-1:0] & mask[W-1:0]);
            chk("cout_run", cout, 1'b0);
         end else begin
            chk("add_a_idle", add_a, 4'h0);
            chk("add_b_idle", add_b, 4'h0);
            chk("add_cin_idle", add_cin, 1'b0);
            chk("sum_hold", sum, hsum);
            chk("cout_hold", cout, hcout);
         end
      end
   end

   // Directed op with literal expectations. mode 1 injects ignored starts at
   // k+1 and k+4 (done cycle). Returns with start low, in the cycle after done.
   task automatic op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic c, input logic s, input int mode,
                     input logic [W-1:0] esum, input logic ecout, output logic [3:0] seq);
      int cnt;
      seq = 4'h0;
      @(posedge clk); #1;
      start = 1'b1; op_a = a; op_b = b; cin = c; sub = s;
      @(posedge clk); #1;                         // edge k accepted
      start = 1'b0; op_a = $urandom; op_b = $urandom; cin = 1'b1; sub = ~s;
      cnt = 0;
      do begin
         @(negedge clk); cnt++;
         if (busy && cnt <= 4) seq[cnt-1] = add_cin;
         if (mode == 1 && cnt == 2) begin start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; end
         if (mode == 1 && cnt == 3) start = 1'b0;
         if (mode == 1 && cnt == N + 1) begin start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; end
      end while (!done && cnt < 20);
      chk({nm, "_latency"}, cnt, N + 1);
      chk({nm, "_sum"}, sum, esum);
      chk({nm, "_cout"}, cout, ecout);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   initial begin
      logic [3:0] seq;
      int dcount;
      #23;
      rst = 1'b0;
      #1;
      chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);   chk("rst_cout", cout, 0);
      chk("rst_add_a", add_a, 0);
      cmp_en = 1;

      op("t1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, seq);
      chk("t1_cin_seq", seq, 4'b1110);

      op("t2", 16'h1234, 16'h4321, 1'b1, 1'b0, 1, 16'h5556, 1'b0, seq);
      dcount = 0;
      for (int i = 0; i < 8; i++) begin @(negedge clk); if (done) dcount++; end
      chk("t3_no_extra_done", dcount, 0);
      chk("t3_sum_held", sum, 16'h5556);
      chk("t3_cout_held", cout, 1'b0);

      // Async reset mid-RUN (cycle k+2), off the clock edge.
      @(posedge clk); #1;
      start = 1'b1; op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); @(posedge clk); #3;
      rst = 1'b1; #1;
      chk("ar_busy", busy, 0); chk("ar_done", done, 0);
      chk("ar_sum", sum, 0);   chk("ar_cout", cout, 0);
      chk("ar_add", {add_a, add_b, add_cin}, 0);
      #12; rst = 1'b0;
      op("t4", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0, 16'h1000, 1'b0, seq);

      // NIBBLES=1 instance.
      @(posedge clk); #1;
      start1 = 1'b1; a1 = 4'hF; b1 = 4'h1; cin1 = 1'b1;
      @(posedge clk); #1; start1 = 1'b0; a1 = 4'h0;
      @(negedge clk);
      chk("n1_busy", busy1, 1'b1); chk("n1_done_early", done1, 1'b0);
      @(negedge clk);
      chk("n1_done", done1, 1'b1); chk("n1_busy_off", busy1, 1'b0);
      chk("n1_sum", sum1, 4'h1);   chk("n1_cout", cout1, 1'b1);

`ifdef NIBSER_SUB_EN
      op("sub1", 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 16'hFFFE, 1'b0, seq);
      op("sub2", 16'h0007, 16'h0005, 1'b0, 1'b1, 0, 16'h0002, 1'b1, seq);
`endif

      // Random traffic. The per-cycle model compare covers it.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (rst) rst = 1'b0;
         start = ($urandom_range(0, 2) == 0);
         op_a = W'($urandom); op_b = W'($urandom);
         cin = 1'($urandom); sub = 1'($urandom);
         if ($urandom_range(0, 399) == 0) begin #2; rst = 1'b1; end
      end
      @(posedge clk); #1; rst = 1'b0; start = 1'b0;
      repeat (N + 3) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
